// File: rtl/eyeriss_pkg.sv
// Shared constants and types for the Eyeriss-style PE grid and its psum collector.
package eyeriss_pkg;

  localparam int NUM_COLS = 14;
  localparam int PSUM_W   = 32;

  localparam logic signed [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic signed [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } collector_state_e;

endpackage

// File: rtl/psum_sat_add.sv
// Combinational signed saturating adder; ovf flags a clamped result.
module psum_sat_add
  import eyeriss_pkg::*;
(
  input  logic signed [PSUM_W-1:0] a,
  input  logic signed [PSUM_W-1:0] b,
  output logic signed [PSUM_W-1:0] sum,
  output logic                     ovf
);

  logic signed [PSUM_W:0] wide;

  // One guard bit exposes overflow: it disagrees with the result sign bit.
  always_comb begin
    wide = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
    ovf  = wide[PSUM_W] != wide[PSUM_W-1];
    sum  = wide[PSUM_W-1:0];
    if (ovf) begin
      sum = wide[PSUM_W] ? PSUM_MIN : PSUM_MAX;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Accumulates per-column grid psums over N passes, then drains one
// (optionally ReLU'd) value per column over a valid/ready stream.
module psum_collector
  import eyeriss_pkg::*;
#(
  parameter int PASS_W = 8,
  parameter int COL_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PASS_W-1:0]        cfg_num_passes,
  input  logic                     cfg_relu,
  input  logic                     psum_valid,
  input  logic signed [PSUM_W-1:0] psum_ins [NUM_COLS],
  output logic                     grid_ready,
  output logic signed [PSUM_W-1:0] ofmap_data,
  output logic [COL_W-1:0]         ofmap_col,
  output logic                     ofmap_valid,
  input  logic                     ofmap_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err_overflow,
  output logic                     err_drop
);

  collector_state_e        state_q, state_d;
  logic signed [PSUM_W-1:0] acc_q [NUM_COLS];
  logic signed [PSUM_W-1:0] acc_d [NUM_COLS];
  logic [PASS_W-1:0]       pass_cnt_q, pass_cnt_d;
  logic [PASS_W-1:0]       num_passes_q, num_passes_d;
  logic [COL_W-1:0]        col_idx_q, col_idx_d;
  logic                    relu_q, relu_d;
  logic                    err_ovf_q, err_ovf_d;
  logic                    err_drop_q, err_drop_d;

  logic signed [PSUM_W-1:0] sat_sum [NUM_COLS];
  logic [NUM_COLS-1:0]     sat_ovf;
  logic                    first_pass;
  logic signed [PSUM_W-1:0] drain_val;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_add
    psum_sat_add u_add (
      .a   (acc_q[c]),
      .b   (psum_ins[c]),
      .sum (sat_sum[c]),
      .ovf (sat_ovf[c])
    );
  end

  assign first_pass = (pass_cnt_q == '0);

  // Next-state logic: config capture, accumulation, drain stepping, error flags.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    pass_cnt_d   = pass_cnt_q;
    num_passes_d = num_passes_q;
    col_idx_d    = col_idx_q;
    relu_d       = relu_q;
    err_ovf_d    = err_ovf_q;
    err_drop_d   = err_drop_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_passes_d = (cfg_num_passes == '0) ? PASS_W'(1) : cfg_num_passes;
          relu_d       = cfg_relu;
          pass_cnt_d   = '0;
          err_ovf_d    = 1'b0;
          err_drop_d   = 1'b0;
          state_d      = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (psum_valid) begin
          // First pass overwrites, so no clear is needed between tiles.
          for (int unsigned c = 0; c < NUM_COLS; c++) begin
            acc_d[c] = first_pass ? psum_ins[c] : sat_sum[c];
          end
          if (!first_pass && (|sat_ovf)) begin
            err_ovf_d = 1'b1;
          end
          pass_cnt_d = pass_cnt_q + PASS_W'(1);
          if (pass_cnt_q == num_passes_q - PASS_W'(1)) begin
            state_d   = ST_DRAIN;
            col_idx_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (ofmap_ready) begin
          if (col_idx_q == COL_W'(NUM_COLS - 1)) begin
            state_d = ST_DONE;
          end else begin
            col_idx_d = col_idx_q + COL_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Applied after the start-clear so a drop in the start cycle still sticks.
    if (psum_valid && (state_q != ST_ACCUM)) begin
      err_drop_d = 1'b1;
    end
  end

  // Outputs decode from registered state only; no path from ofmap_ready.
  always_comb begin
    drain_val = acc_q[col_idx_q];
    if (relu_q && drain_val[PSUM_W-1]) begin
      drain_val = '0;
    end
    grid_ready   = (state_q == ST_ACCUM);
    busy         = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    ofmap_valid  = (state_q == ST_DRAIN);
    done         = (state_q == ST_DONE);
    ofmap_col    = (state_q == ST_DRAIN) ? col_idx_q : '0;
    ofmap_data   = (state_q == ST_DRAIN) ? drain_val : '0;
    err_overflow = err_ovf_q;
    err_drop     = err_drop_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pass_cnt_q   <= '0;
      num_passes_q <= '0;
      col_idx_q    <= '0;
      relu_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_drop_q   <= 1'b0;
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pass_cnt_q   <= pass_cnt_d;
      num_passes_q <= num_passes_d;
      col_idx_q    <= col_idx_d;
      relu_q       <= relu_d;
      err_ovf_q    <= err_ovf_d;
      err_drop_q   <= err_drop_d;
      acc_q        <= acc_d;
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: per-tile reference model (column sums with
// saturation and ReLU) feeding an expected-beat queue, checked by a monitor.
module tb_psum_collector;
  import eyeriss_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start = 1'b0;
  logic [7:0]               cfg_num_passes = '0;
  logic                     cfg_relu = 1'b0;
  logic                     psum_valid = 1'b0;
  logic signed [PSUM_W-1:0] psum_ins [NUM_COLS];
  logic                     grid_ready;
  logic signed [PSUM_W-1:0] ofmap_data;
  logic [3:0]               ofmap_col;
  logic                     ofmap_valid;
  logic                     ofmap_ready = 1'b0;
  logic                     busy, done, err_overflow, err_drop;

  psum_collector #(.PASS_W(8), .COL_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_num_passes (cfg_num_passes),
    .cfg_relu       (cfg_relu),
    .psum_valid     (psum_valid),
    .psum_ins       (psum_ins),
    .grid_ready     (grid_ready),
    .ofmap_data     (ofmap_data),
    .ofmap_col      (ofmap_col),
    .ofmap_valid    (ofmap_valid),
    .ofmap_ready    (ofmap_ready),
    .busy           (busy),
    .done           (done),
    .err_overflow   (err_overflow),
    .err_drop       (err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                     col;
    logic signed [PSUM_W-1:0] data;
  } beat_t;

  int n_cmp = 0;
  int n_err = 0;

  beat_t                    exp_q [$];
  logic signed [PSUM_W-1:0] pd  [8][NUM_COLS];
  logic signed [PSUM_W-1:0] got [NUM_COLS];
  int                       beats_acc = 0;
  int                       done_cnt = 0;
  bit                       exp_ovf = 0;
  bit                       exp_drop = 0;

  bit                       prev_stall = 0;
  bit                       last_acc_prev = 0;
  logic [3:0]               prev_col;
  logic signed [PSUM_W-1:0] prev_data;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops expected beats on each accepted transfer, checks holds and done timing.
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      check("reset_outputs", {grid_ready, ofmap_valid, busy, done, err_overflow, err_drop,
                              |ofmap_data, |ofmap_col}, 0);
      prev_stall    = 0;
      last_acc_prev = 0;
    end else begin
      check("done_timing", done, last_acc_prev);
      if (done) done_cnt++;
      last_acc_prev = 0;
      if (prev_stall) begin
        check("hold_valid", ofmap_valid, 1);
        check("hold_col", ofmap_col, prev_col);
        check("hold_data", ofmap_data, prev_data);
      end
      prev_stall = ofmap_valid && !ofmap_ready;
      prev_col   = ofmap_col;
      prev_data  = ofmap_data;
      if (ofmap_valid) check("busy_in_drain", busy, 1);
      if (ofmap_valid && ofmap_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("beat_col", ofmap_col, b.col);
          check("beat_data", ofmap_data, b.data);
          got[ofmap_col] = ofmap_data;
          beats_acc++;
          if (b.col == NUM_COLS - 1) last_acc_prev = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pd();
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < NUM_COLS; c++)
        pd[p][c] = '0;
  endtask

  task automatic run_tile(input int n_cfg, input bit relu, input int stall_col,
                          input int stall_len, input bit rand_ready, input bit simul_drop,
                          input int abort_after, input bit gaps);
    int     n_eff;
    longint acc;
    longint v;
    int     guard;
    int     stall_left;
    int     base_done;
    n_eff = (n_cfg == 0) ? 1 : n_cfg;
    // Reference: per-column running sum clamped after every add, ReLU on the way out.
    exp_ovf = 0;
    for (int c = 0; c < NUM_COLS; c++) begin
      acc = pd[0][c];
      for (int p = 1; p < n_eff; p++) begin
        acc = acc + pd[p][c];
        if (acc > 64'sd2147483647) begin acc = 64'sd2147483647; exp_ovf = 1; end
        if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; exp_ovf = 1; end
      end
      v = (relu && acc < 0) ? 0 : acc;
      exp_q.push_back('{col: c, data: v[31:0]});
      got[c] = 32'h5A5A5A5A;
    end
    exp_drop  = simul_drop;
    beats_acc = 0;
    base_done = done_cnt;

    start          = 1;
    cfg_num_passes = n_cfg[7:0];
    cfg_relu       = relu;
    psum_valid     = simul_drop;
    psum_ins       = pd[7];
    tick();
    start          = 0;
    psum_valid     = 0;
    cfg_num_passes = 8'($urandom);
    cfg_relu       = 1'($urandom);

    for (int p = 0; p < n_eff; p++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          psum_valid = 0;
          start      = 1'($urandom);
          @(negedge clk);
          check("accum_ready_idle", grid_ready, 1);
          check("accum_busy", busy, 1);
          tick();
        end
      end
      psum_valid = 1;
      psum_ins   = pd[p];
      @(negedge clk);
      check("grid_ready", grid_ready, 1);
      check("no_valid_in_accum", ofmap_valid, 0);
      tick();
    end
    psum_valid = 0;
    start      = 0;
    for (int c = 0; c < NUM_COLS; c++) psum_ins[c] = $urandom;

    @(negedge clk);
    check("first_beat_valid", ofmap_valid, 1);
    check("first_beat_col", ofmap_col, 0);
    check("ready_low_in_drain", grid_ready, 0);
    tick();

    stall_left = stall_len;
    guard      = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      if (abort_after >= 0 && beats_acc >= abort_after) break;
      if (ofmap_valid && ofmap_col == stall_col[3:0] && stall_left > 0) begin
        ofmap_ready = 0;
        stall_left--;
      end else begin
        ofmap_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (rand_ready && $urandom_range(0, 7) == 0) begin
        psum_valid = 1;
        exp_drop   = 1;
      end else begin
        psum_valid = 0;
      end
      start = rand_ready ? 1'($urandom) : 1'b0;
      tick();
      guard++;
    end
    psum_valid = 0;
    start      = 0;

    if (abort_after >= 0 && exp_q.size() > 0) begin
      rst = 0;
      #1;
      check("abort_valid", ofmap_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_beats", beats_acc, abort_after);
      exp_q.delete();
      ofmap_ready = 0;
      exp_ovf  = 0;
      exp_drop = 0;
      repeat (2) tick();
      rst = 1;
      tick();
      @(negedge clk);
      check("after_abort_busy", busy, 0);
      check("after_abort_valid", ofmap_valid, 0);
      tick();
      return;
    end

    ofmap_ready = 0;
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick();
    tick();
    @(negedge clk);
    check("done_count", done_cnt - base_done, 1);
    check("beats_total", beats_acc, NUM_COLS);
    check("idle_busy", busy, 0);
    check("idle_valid", ofmap_valid, 0);
    check("err_overflow", err_overflow, exp_ovf);
    check("err_drop", err_drop, exp_drop);
    tick();
  endtask

  task automatic idle_drop();
    psum_valid = 1;
    tick();
    psum_valid = 0;
    exp_drop   = 1;
    @(negedge clk);
    check("idle_drop_flag", err_drop, 1);
    check("idle_drop_ovf_kept", err_overflow, exp_ovf);
    check("idle_drop_busy", busy, 0);
    tick();
  endtask

  initial begin
    for (int c = 0; c < NUM_COLS; c++) psum_ins[c] = '0;
    clear_pd();
    repeat (3) tick();
    rst = 1;
    tick();

    // Single pass, one hot column.
    clear_pd();
    pd[0][2] = 90;
    run_tile(1, 0, -1, 0, 0, 0, -1, 0);
    check("single_col2", got[2], 90);
    check("single_col0", got[0], 0);
    check("single_col13", got[13], 0);

    // Three passes of c, 10c, 100c.
    clear_pd();
    for (int c = 0; c < NUM_COLS; c++) begin
      pd[0][c] = c;
      pd[1][c] = 10 * c;
      pd[2][c] = 100 * c;
    end
    run_tile(3, 0, -1, 0, 0, 0, -1, 1);
    check("three_col13", got[13], 1443);
    check("three_col5", got[5], 555);

    // ReLU on and off with the same stimulus.
    clear_pd();
    pd[0][0] = -5;
    pd[0][1] = 7;
    run_tile(1, 1, -1, 0, 0, 0, -1, 0);
    check("relu_col0", got[0], 0);
    check("relu_col1", got[1], 7);
    run_tile(1, 0, -1, 0, 0, 0, -1, 0);
    check("norelu_col0", got[0], -5);

    // Backpressure: three stalled cycles at column 4.
    run_tile(1, 0, 4, 3, 0, 0, -1, 0);
    check("bp_beats", beats_acc, 14);
    check("bp_col1", got[1], 7);

    // Saturation both directions, then a drop in IDLE, then a clearing start.
    clear_pd();
    pd[0][0] = 32'h7FFFFFF0;
    pd[1][0] = 32'h7FFFFFF0;
    pd[0][1] = 32'h80000010;
    pd[1][1] = 32'h80000010;
    run_tile(2, 0, -1, 0, 0, 0, -1, 0);
    check("sat_pos", got[0], 32'sh7FFFFFFF);
    check("sat_neg", got[1], -64'sd2147483648);
    check("sat_flag", err_overflow, 1);
    idle_drop();
    clear_pd();
    pd[0][3] = 42;
    run_tile(0, 0, -1, 0, 0, 0, -1, 0);
    check("npass0_col3", got[3], 42);
    check("cleared_ovf", err_overflow, 0);
    check("cleared_drop", err_drop, 0);

    // Start accepted with a simultaneous pass: pass dropped, flag set.
    for (int c = 0; c < NUM_COLS; c++) pd[7][c] = 1000 + c;
    run_tile(1, 0, -1, 0, 0, 1, -1, 0);
    check("simul_col3", got[3], 42);

    // Reset in the middle of a drain, then a clean tile.
    run_tile(1, 0, -1, 0, 0, 0, 6, 0);
    run_tile(1, 0, -1, 0, 1, 0, -1, 0);
    check("post_reset_col3", got[3], 42);
    check("post_reset_col0", got[0], 0);

    // Randomized tiles.
    repeat (10) begin
      for (int p = 0; p < 8; p++)
        for (int c = 0; c < NUM_COLS; c++)
          pd[p][c] = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 2000) - 1000);
      run_tile($urandom_range(0, 4), 1'($urandom), $urandom_range(0, 13),
               $urandom_range(0, 4), 1, 1'($urandom), -1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
